// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream multiplexer with a round-robin
// arbiter and a registered output stage. Output latency is one cycle and the
// stage sustains full throughput. With PKT_MODE=1 the grant is held on one
// channel from its first beat until its in_last beat is accepted.

module rr_stream_mux #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_CH   = 4,
    parameter  int PKT_MODE = 0,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_last
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CH_W-1:0]    r_ptr;
    logic [CH_W-1:0]    r_lock_ch;
    logic [CH_W-1:0]    w_lock_nxt;

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic [CH_W-1:0]    r_out_ch;
    logic               r_out_last;

    logic               w_load;
    logic               w_found;
    logic               w_accept;
    logic               w_last;
    logic [CH_W-1:0]    w_win;
    logic [CH_W-1:0]    w_idx;
    logic [CH_W-1:0]    w_ptr_nxt;

    // The output register may load when it is empty or being drained this
    // cycle, which is what lets drain and refill overlap without bubbles.
    assign w_load = !r_out_valid || out_ready;

    // Pick the winner: the locked channel only, or the first valid channel
    // searching upward from the round-robin pointer with wrap-around.
    always_comb begin
        // NOTE: every variable written here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        if (r_state == ST_LOCKED) begin
            w_found = in_valid[r_lock_ch];
            w_win   = r_lock_ch;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                w_idx = CH_W'((int'(r_ptr) + k) % NUM_CH);
                if (!w_found && in_valid[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = w_idx;
                end
            end
        end
    end

    assign w_accept  = w_load && w_found;
    assign w_last    = in_last[w_win];
    assign in_ready  = w_accept ? (NUM_CH'(1) << w_win) : '0;
    assign w_ptr_nxt = (w_win == CH_W'(NUM_CH - 1)) ? '0 : w_win + CH_W'(1);

    // Packet lock FSM next state: lock on a non-last beat, release on the
    // last beat of the locked channel. Without packet mode it never leaves IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_ch;
        if (PKT_MODE != 0 && w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_last) begin
                        w_state_nxt = ST_LOCKED;
                        w_lock_nxt  = w_win;
                    end
                end
                ST_LOCKED: begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state and lock channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_ch <= w_lock_nxt;
        end
    end

    // Round-robin pointer: moves past the winner on every accepted beat, or
    // only on the closing beat of a packet in packet mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept && (PKT_MODE == 0 || w_last)) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Output register: refill from the winner, or go empty while keeping the
    // last payload when nobody is eligible; hold everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_data <= in_data[w_win*DATA_W +: DATA_W];
                r_out_ch   <= w_win;
                r_out_last <= w_last;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed bench for rr_stream_mux. dut0 runs per-beat
// arbitration, dut1 runs packet mode. Expected beats are queued when the
// stimulus makes an acceptance expected and are compared when the output
// register hands a beat downstream.

module tb_rr_stream_mux;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic clk;
    logic rst_n;

    logic [NUM_CH-1:0]        v0, r0, l0;
    logic [NUM_CH*DATA_W-1:0] d0;
    logic                     ov0, or0, ol0;
    logic [DATA_W-1:0]        od0;
    logic [CH_W-1:0]          oc0;

    logic [NUM_CH-1:0]        v1, r1, l1;
    logic [NUM_CH*DATA_W-1:0] d1;
    logic                     ov1, or1, ol1;
    logic [DATA_W-1:0]        od1;
    logic [CH_W-1:0]          oc1;

    beat_t q0[$];
    beat_t q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    rr_stream_mux #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .PKT_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v0), .in_ready(r0), .in_data(d0), .in_last(l0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ch(oc0), .out_last(ol0)
    );

    rr_stream_mux #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .PKT_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(r1), .in_data(d1), .in_last(l1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ch(oc1), .out_last(ol1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input int ch, input logic [DATA_W-1:0] d, input logic l);
        q0.push_back('{ch: CH_W'(ch), data: d, last: l});
    endtask

    task automatic push1(input int ch, input logic [DATA_W-1:0] d, input logic l);
        q1.push_back('{ch: CH_W'(ch), data: d, last: l});
    endtask

    // Output-side scoreboard: a beat leaves at the coming edge when
    // out_valid && out_ready are both high at the falling edge.
    task automatic mon();
        beat_t e;
        if (ov0 && or0) begin
            check("sb0_nonempty", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("sb0_beat", 64'({oc0, od0, ol0}), 64'(e));
            end
        end
        if (ov1 && or1) begin
            check("sb1_nonempty", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("sb1_beat", 64'({oc1, od1, ol1}), 64'(e));
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] pat(input int i);
        return DATA_W'(32'h1111_1111 * (i + 1));
    endfunction

    initial begin
        rst_n = 1'b0;
        v0 = '0; l0 = '0; d0 = '0; or0 = 1'b1;
        v1 = '0; l1 = '0; d1 = '0; or1 = 1'b1;

        // Reset values
        to_neg();
        check("rst_ov0", 64'(ov0), 64'd0);
        check("rst_od0", 64'(od0), 64'd0);
        check("rst_oc0", 64'(oc0), 64'd0);
        check("rst_ol0", 64'(ol0), 64'd0);
        check("rst_ov1", 64'(ov1), 64'd0);
        check("rst_r0",  64'(r0),  64'd0);
        to_pos();
        to_pos();
        rst_n = 1'b1;

        // 1: single channel 2 beat
        v0 = 4'b0100;
        d0[2*DATA_W +: DATA_W] = 32'hAAAA_AAAA;
        to_neg();
        check("t1_in_ready", 64'(r0), 64'b0100);
        push0(2, 32'hAAAA_AAAA, 1'b0);
        to_pos();
        check("t1_out_valid", 64'(ov0), 64'd1);
        check("t1_out_data",  64'(od0), 64'hAAAA_AAAA);
        check("t1_out_ch",    64'(oc0), 64'd2);
        v0 = '0;
        to_neg();
        to_pos();
        check("t1_empty", 64'(ov0), 64'd0);

        // 2: all channels valid, rotation 0,1,2,3,0,1 with no idle cycles
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_CH; i++) d0[i*DATA_W +: DATA_W] = pat(i);
        v0 = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            to_neg();
            check("t2_in_ready", 64'(r0), 64'(4'b0001 << (k % NUM_CH)));
            push0(k % NUM_CH, pat(k % NUM_CH), 1'b0);
            to_pos();
            check("t2_no_bubble", 64'(ov0), 64'd1);
        end
        v0 = '0;
        to_neg();
        to_pos();

        // 3: output stall for 3 cycles, then resume from the pointer (ch2)
        or0 = 1'b0;
        v0  = 4'b1111;
        to_neg();
        check("t3_in_ready_load", 64'(r0), 64'b0100);
        push0(2, pat(2), 1'b0);
        to_pos();
        for (int k = 0; k < 3; k++) begin
            to_neg();
            check("t3_stall_ready", 64'(r0), 64'd0);
            check("t3_stall_data",  64'(od0), 64'(pat(2)));
            check("t3_stall_ch",    64'(oc0), 64'd2);
            check("t3_stall_valid", 64'(ov0), 64'd1);
            to_pos();
        end
        or0 = 1'b1;
        to_neg();
        check("t3_resume_ch3", 64'(r0), 64'b1000);
        push0(3, pat(3), 1'b0);
        to_pos();
        to_neg();
        check("t3_resume_ch0", 64'(r0), 64'b0001);
        push0(0, pat(0), 1'b0);
        to_pos();
        v0 = '0;
        to_neg();
        to_pos();

        // 4: packet mode, ch1 three-beat packet while ch0 and ch3 wait
        d1[0*DATA_W +: DATA_W] = 32'h0000_00C0;
        d1[3*DATA_W +: DATA_W] = 32'h0000_00C3;
        v1 = 4'b0001; l1 = 4'b0001;
        to_neg();
        check("t4_ch0_single", 64'(r1), 64'b0001);
        push1(0, 32'h0000_00C0, 1'b1);
        to_pos();
        v1 = 4'b1011; l1 = 4'b1001;
        for (int b = 1; b <= 3; b++) begin
            d1[1*DATA_W +: DATA_W] = 32'h1000_0000 + DATA_W'(b);
            if (b == 3) l1 = 4'b1011;
            to_neg();
            check("t4_pkt_ready", 64'(r1), 64'b0010);
            push1(1, 32'h1000_0000 + DATA_W'(b), b == 3);
            to_pos();
        end
        v1 = 4'b1001;
        to_neg();
        check("t4_after_ch3", 64'(r1), 64'b1000);
        push1(3, 32'h0000_00C3, 1'b1);
        to_pos();
        v1 = 4'b0001;
        to_neg();
        check("t4_after_ch0", 64'(r1), 64'b0001);
        push1(0, 32'h0000_00C0, 1'b1);
        to_pos();
        v1 = '0;
        to_neg();
        to_pos();

        // 5: locked ch1 drops valid for 2 cycles, ch0 must stay blocked
        d1[1*DATA_W +: DATA_W] = 32'h2000_0001;
        v1 = 4'b0011; l1 = 4'b0000;
        to_neg();
        check("t5_lock_ch1", 64'(r1), 64'b0010);
        push1(1, 32'h2000_0001, 1'b0);
        to_pos();
        v1 = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            to_neg();
            check("t5_gap_ready", 64'(r1), 64'd0);
            to_pos();
            check("t5_gap_valid", 64'(ov1), 64'd0);
        end
        d1[1*DATA_W +: DATA_W] = 32'h2000_0002;
        v1 = 4'b0011; l1 = 4'b0011;
        to_neg();
        check("t5_ch1_last", 64'(r1), 64'b0010);
        push1(1, 32'h2000_0002, 1'b1);
        to_pos();
        v1 = 4'b0001;
        to_neg();
        check("t5_ch0_after", 64'(r1), 64'b0001);
        push1(0, 32'h0000_00C0, 1'b1);
        to_pos();
        v1 = '0;
        to_neg();
        to_pos();

        // 6: asynchronous reset while LOCKED with a full output
        d1[2*DATA_W +: DATA_W] = 32'h0000_00D2;
        v1 = 4'b0100; l1 = 4'b0000;
        to_neg();
        check("t6_lock_ch2", 64'(r1), 64'b0100);
        push1(2, 32'h0000_00D2, 1'b0);
        to_pos();
        check("t6_full_before_rst", 64'(ov1), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_ov", 64'(ov1), 64'd0);
        check("t6_async_oc", 64'(oc1), 64'd0);
        check("t6_async_od", 64'(od1), 64'd0);
        q1.delete();
        d1[0*DATA_W +: DATA_W] = 32'h0000_00E0;
        d1[1*DATA_W +: DATA_W] = 32'h0000_00E1;
        v1 = 4'b0011; l1 = 4'b0011;
        #1;
        rst_n = 1'b1;
        to_neg();
        check("t6_restart_ready", 64'(r1), 64'b0001);
        push1(0, 32'h0000_00E0, 1'b1);
        to_pos();
        check("t6_restart_ch", 64'(oc1), 64'd0);
        v1 = '0;
        to_neg();
        to_pos();

        check("sb0_drained", 64'(q0.size()), 64'd0);
        check("sb1_drained", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
